// File: rtl/seq_mag_compare_ctrl.sv
// Sequencer that compares two WIDTH-bit words MSB pair first through one external 2-bit comparator slice.
// Optional macro SEQ_CMP_EARLY_EXIT_EN: stop at the first mismatching pair instead of running all N pairs.
module seq_mag_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    input  logic [2:0]       slice_y,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic             err
);

    localparam int N     = WIDTH / 2;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;

    logic pair_eq;
    logic pair_gt;
    logic pair_lt;

    assign pair_eq = (slice_y == 3'b001);
    assign pair_gt = (slice_y == 3'b100);
    assign pair_lt = (slice_y == 3'b010);

    // Pair selection: idx counts down from the MSB pair.
    always_comb begin
        a_shift = a_lat >> {idx, 1'b0};
        b_shift = b_lat >> {idx, 1'b0};
        slice_a = 2'b00;
        slice_b = 2'b00;
        if (state == CMP) begin
            slice_a = a_shift[1:0];
            slice_b = b_shift[1:0];
        end
    end

`ifndef SEQ_CMP_EARLY_EXIT_EN
    // First mismatch wins; later pairs are still walked so timing is data independent.
    logic rec_gt;
    logic rec_lt;
    logic mm_gt;
    logic mm_lt;

    assign mm_gt = rec_gt | (~rec_lt & pair_gt);
    assign mm_lt = rec_lt | (~rec_gt & pair_lt);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            a_lat <= '0;
            b_lat <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            gt    <= 1'b0;
            err   <= 1'b0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
            rec_gt <= 1'b0;
            rec_lt <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat <= a_in;
                        b_lat <= b_in;
                        idx   <= IDX_W'(N - 1);
                        eq    <= 1'b0;
                        lt    <= 1'b0;
                        gt    <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= CMP;
`ifndef SEQ_CMP_EARLY_EXIT_EN
                        rec_gt <= 1'b0;
                        rec_lt <= 1'b0;
`endif
                    end
                end

                CMP: begin
                    if (!(pair_eq || pair_gt || pair_lt)) begin
                        err   <= 1'b1;
                        eq    <= 1'b0;
                        lt    <= 1'b0;
                        gt    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        idx   <= '0;
                        state <= FIN;
`ifdef SEQ_CMP_EARLY_EXIT_EN
                    end else if (pair_eq && (idx != '0)) begin
                        idx <= idx - 1'b1;
                    end else begin
                        gt    <= pair_gt;
                        lt    <= pair_lt;
                        eq    <= pair_eq;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        idx   <= '0;
                        state <= FIN;
                    end
`else
                    end else if (idx != '0) begin
                        rec_gt <= mm_gt;
                        rec_lt <= mm_lt;
                        idx    <= idx - 1'b1;
                    end else begin
                        gt    <= mm_gt;
                        lt    <= mm_lt;
                        eq    <= ~(mm_gt | mm_lt);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
`endif
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_compare_ctrl.sv
// Self-checking bench for seq_mag_compare_ctrl (WIDTH=8): behavioural slice plus word-level reference model.
module tb_seq_mag_compare_ctrl;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic [2:0]       slice_y;
    logic             busy, done, eq, lt, gt, err;
    logic             bad = 1'b0;

    int tests = 0;
    int fails = 0;

    seq_mag_compare_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .slice_a(slice_a), .slice_b(slice_b), .slice_y(slice_y),
        .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural 2-bit comparator slice, with an injectable illegal code.
    always_comb begin
        slice_y = 3'b001;
        if (bad)                    slice_y = 3'b011;
        else if (slice_a > slice_b) slice_y = 3'b100;
        else if (slice_a < slice_b) slice_y = 3'b010;
    end

    function automatic logic [1:0] pair_of(input logic [WIDTH-1:0] w, input int j);
        logic [WIDTH-1:0] s;
        s = w >> (2 * (N - 1 - j));
        return s[1:0];
    endfunction

    // {err,gt,lt,eq} from plain integer comparison
    function automatic logic [3:0] ref_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (a > b) return 4'b0100;
        if (a < b) return 4'b0010;
        return 4'b0001;
    endfunction

    // Edges from acceptance until done is visible
    function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        for (int j = 0; j < N; j++)
            if (pair_of(a, j) != pair_of(b, j)) return j + 1;
`endif
        return N;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit keep);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) start = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
    endtask

    task automatic finish(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit intrude, input int bad_cyc, input bit post);
        int         lat;
        int         exp_lat;
        logic [3:0] exp_res;
        lat     = 0;
        exp_lat = (bad_cyc > 0) ? bad_cyc : ref_lat(a, b);
        exp_res = (bad_cyc > 0) ? 4'b1000 : ref_res(a, b);
        chk("cleared", {err, gt, lt, eq}, 4'b0000);
        for (int cyc = 1; cyc <= 3 * N; cyc++) begin
            chk("busy", busy, 1'b1);
            if (cyc <= N) begin
                chk("pair_a", slice_a, pair_of(a, cyc - 1));
                chk("pair_b", slice_b, pair_of(b, cyc - 1));
            end
            if (intrude && cyc == 2) begin
                a_in  = ~a;
                b_in  = a;
                start = 1'b1;
            end
            if (intrude && cyc == 3) start = 1'b0;
            if (bad_cyc == cyc) bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bad = 1'b0;
            if (done) begin
                lat = cyc;
                break;
            end
        end
        if (lat == 0) chk("timeout", 0, 1);
        chk("latency", lat, exp_lat);
        chk("result", {err, gt, lt, eq}, exp_res);
        chk("fin_busy", busy, 1'b0);
        chk("fin_slice", {slice_a, slice_b}, 4'b0000);
        if (post) begin
            @(posedge clk);
            @(negedge clk);
            chk("done_pulse", done, 1'b0);
            chk("held", {err, gt, lt, eq}, exp_res);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;

        @(negedge clk);
        #1;
        chk("rst_outs", {busy, done, eq, lt, gt, err, slice_a, slice_b}, 10'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal words
        issue(8'hA5, 8'hA5, 1'b0);
        finish(8'hA5, 8'hA5, 1'b0, 0, 1'b1);
        chk("eq_a5", {err, gt, lt, eq}, 4'b0001);
        // Less-than decided only on the last pair
        issue(8'h12, 8'h13, 1'b0);
        finish(8'h12, 8'h13, 1'b0, 0, 1'b1);
        // Greater-than decided on the MSB pair; later pairs flip
        issue(8'h80, 8'h7F, 1'b0);
        finish(8'h80, 8'h7F, 1'b0, 0, 1'b1);
        chk("gt_80", {err, gt, lt, eq}, 4'b0100);

        // Start during CMP is ignored
        issue(8'h3C, 8'h3C, 1'b0);
        finish(8'h3C, 8'h3C, 1'b1, 0, 1'b1);
        chk("idle_after_intrude", busy, 1'b0);

        // Start held high re-triggers on the IDLE cycle after FIN
        issue(8'h47, 8'h46, 1'b1);
        a_in = 8'h47;
        b_in = 8'h46;
        finish(8'h47, 8'h46, 1'b0, 0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("hold_idle_busy", busy, 1'b0);
        chk("hold_idle_done", done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("hold_retrigger", busy, 1'b1);
        start = 1'b0;
        finish(8'h47, 8'h46, 1'b0, 0, 1'b1);

        // Non-one-hot slice result on the 2nd compare cycle
        issue(8'h55, 8'h55, 1'b0);
        finish(8'h55, 8'h55, 1'b0, 2, 1'b1);

        // Asynchronous reset in the 2nd CMP cycle
        issue(8'h12, 8'h34, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outs", {busy, done, eq, lt, gt, err, slice_a, slice_b}, 10'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_nodone", done, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_done", done, 1'b0);
        issue(8'hC3, 8'hC7, 1'b0);
        finish(8'hC3, 8'hC7, 1'b0, 0, 1'b1);

        // Randomized operands, biased towards equal or near-equal words
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0:       rb = $urandom;
                1:       rb = ra;
                default: rb = ra ^ (8'h01 << $urandom_range(0, 7));
            endcase
            issue(ra, rb, 1'b0);
            finish(ra, rb, 1'b0, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
